mode_select_ram: RTL and testbench

MODE_SELECT_RAM -- requirements
Module: mode_select_ram

---
 rtl/mode_select_ram.sv | 168 ++++++++++++++++
 tb/tb_mode_select_ram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_select_ram.sv
// Simple dual-port RAM (one write port, one read port) with a self-clearing INIT sweep,
// a configurable read/write collision policy and an optional output pipeline stage.
module mode_select_ram #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MODE          = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_VALUE    = 100
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic [7:0]               collision_count
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [DATA_WIDTH-1:0]    INIT_WORD = DATA_WIDTH'(INIT_VALUE);

    logic [0:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]               coll_cnt_q, coll_cnt_d;
    logic [DATA_WIDTH-1:0]    dout1_q, dout1_d;
    logic                     vld1_q, vld1_d;

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    logic                     ready;
    logic                     rd_acc;
    logic                     coll;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    rd_word;

    assign ready   = (state_q == ST_READY);
    assign rd_acc  = ready && re;
    assign coll    = ready && we && re && (addr_a == addr_b);
    assign rd_word = mem_q[addr_b];

    // ---------------- FSM and init pointer ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- Memory array (never reset; cleared by the sweep) ----------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_a;
        mem_wdata = din;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = INIT_WORD;
            end else begin
                mem_we = we;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- Read stage with collision policy ----------------
    // rd_word is the pre-edge contents, so READ_FIRST falls out naturally.
    always_comb begin
        vld1_d  = rd_acc;
        dout1_d = dout1_q;
        if (rd_acc) begin
            case (MODE)
                1:       dout1_d = coll ? din : rd_word;
                2: begin
                    if (coll) begin
                        vld1_d = 1'b0;
                    end else begin
                        dout1_d = rd_word;
                    end
                end
                default: dout1_d = rd_word;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            dout1_q <= dout1_d;
            vld1_q  <= vld1_d;
        end
    end

    // ---------------- Saturating collision counter ----------------
    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll && (coll_cnt_q != 8'hFF)) begin
            coll_cnt_d = coll_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coll_cnt_q <= '0;
        end else begin
            coll_cnt_q <= coll_cnt_d;
        end
    end

    // ---------------- Optional output stage ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] dout2_q;
            logic                  vld2_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dout2_q <= '0;
                    vld2_q  <= 1'b0;
                end else begin
                    dout2_q <= dout1_q;
                    vld2_q  <= vld1_q;
                end
            end

            assign dout       = dout2_q;
            assign dout_valid = vld2_q;
        end else begin : g_no_out_reg
            assign dout       = dout1_q;
            assign dout_valid = vld1_q;
        end
    endgenerate

    assign busy            = (state_q == ST_INIT);
    assign collision_count = coll_cnt_q;

endmodule

// File: tb/tb_mode_select_ram.sv
// Bench for mode_select_ram: four instances (MODE 0/1/2, plus MODE 0 with OUT_REG) share one
// stimulus stream and are compared each cycle against a word-level reference model.
module tb_mode_select_ram;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [3:0] addr_a = '0;
    logic [7:0] din = '0;
    logic       re = 1'b0;
    logic [3:0] addr_b = '0;

    logic [7:0] dout_w [4];
    logic       dv_w   [4];
    logic       bz_w   [4];
    logic [7:0] cc_w   [4];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mode_select_ram #(.MODE(0), .OUT_REG(0)) u_m0 (
        .clock(clock), .reset(reset), .we(we), .addr_a(addr_a), .din(din), .re(re),
        .addr_b(addr_b), .dout(dout_w[0]), .dout_valid(dv_w[0]), .busy(bz_w[0]),
        .collision_count(cc_w[0]));
    mode_select_ram #(.MODE(1), .OUT_REG(0)) u_m1 (
        .clock(clock), .reset(reset), .we(we), .addr_a(addr_a), .din(din), .re(re),
        .addr_b(addr_b), .dout(dout_w[1]), .dout_valid(dv_w[1]), .busy(bz_w[1]),
        .collision_count(cc_w[1]));
    mode_select_ram #(.MODE(2), .OUT_REG(0)) u_m2 (
        .clock(clock), .reset(reset), .we(we), .addr_a(addr_a), .din(din), .re(re),
        .addr_b(addr_b), .dout(dout_w[2]), .dout_valid(dv_w[2]), .busy(bz_w[2]),
        .collision_count(cc_w[2]));
    mode_select_ram #(.MODE(0), .OUT_REG(1)) u_m0r (
        .clock(clock), .reset(reset), .we(we), .addr_a(addr_a), .din(din), .re(re),
        .addr_b(addr_b), .dout(dout_w[3]), .dout_valid(dv_w[3]), .busy(bz_w[3]),
        .collision_count(cc_w[3]));

    // Reference model: word array, count of init writes done, collision total, and
    // the expected visible (valid, data) per instance.
    int         m_mem [16];
    int         m_init_done;
    int         m_coll;
    logic       e_v [4];
    logic [7:0] e_d [4];
    logic [8:0] oreg_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.busy%0d", tag, k), 32'(bz_w[k]), 32'(m_init_done < 16));
            chk($sformatf("%s.ccnt%0d", tag, k), 32'(cc_w[k]), 32'(m_coll));
            chk($sformatf("%s.dv%0d", tag, k), 32'(dv_w[k]), 32'(e_v[k]));
            chk($sformatf("%s.dout%0d", tag, k), 32'(dout_w[k]), 32'(e_d[k]));
        end
    endtask

    task automatic model_reset();
        m_init_done = 0;
        m_coll      = 0;
        for (int k = 0; k < 4; k++) begin
            e_v[k] = 1'b0;
            e_d[k] = 8'h00;
        end
        oreg_q.delete();
        oreg_q.push_back(9'h000);
    endtask

    task automatic model_edge(input logic w, input int aa, input int d, input logic r, input int ab);
        logic       rv [3];
        int         rd [3];
        logic       c;
        int         old;
        logic [8:0] head;
        if (m_init_done < 16) begin
            m_mem[m_init_done] = 100;
            m_init_done++;
            for (int k = 0; k < 3; k++) begin
                rv[k] = 1'b0;
                rd[k] = 0;
            end
        end else begin
            c   = w && r && (aa == ab);
            old = m_mem[ab];
            rv[0] = r;          rd[0] = old;
            rv[1] = r;          rd[1] = c ? d : old;
            rv[2] = r && !c;    rd[2] = old;
            if (c && m_coll < 255) m_coll++;
            if (w) m_mem[aa] = d;
        end
        for (int k = 0; k < 3; k++) begin
            e_v[k] = rv[k];
            if (rv[k]) e_d[k] = 8'(rd[k]);
        end
        oreg_q.push_back({rv[0], 8'(rd[0])});
        head   = oreg_q.pop_front();
        e_v[3] = head[8];
        if (head[8]) e_d[3] = head[7:0];
    endtask

    task automatic step(input logic w, input int aa, input int d, input logic r, input int ab);
        we     = w;
        addr_a = 4'(aa);
        din    = 8'(d);
        re     = r;
        addr_b = 4'(ab);
        @(posedge clock);
        model_edge(w, aa, d, r, ab);
        #1;
        check_all("step");
    endtask

    task automatic rand_step(input int amax);
        step(1'($urandom_range(0, 1)), int'($urandom_range(0, amax)), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, amax)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clock);
        @(posedge clock);
        #1;
        check_all("reset_hold");
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        model_reset();

        // Power-up: init sweep with ignored traffic, then read everything back
        do_reset();
        repeat (16) rand_step(15);
        chk("busy_after_16", 32'(bz_w[0]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 0, 0, 1'b1, i);
            chk($sformatf("init_word%0d", i), 32'(dout_w[0]), 32'd100);
        end

        // Reset in the middle of INIT restarts the sweep
        do_reset();
        repeat (7) rand_step(15);
        chk("busy_mid_init", 32'(bz_w[0]), 32'd1);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, i, 8'h33, 1'b1, i);
            chk("busy_fresh_init", 32'(bz_w[0]), 32'd1);
        end
        step(1'b1, 15, 8'h33, 1'b1, 15);
        chk("busy_fresh_done", 32'(bz_w[0]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 0, 0, 1'b1, i);
            chk($sformatf("reinit_word%0d", i), 32'(dout_w[0]), 32'd100);
        end

        // Collision behaviour of each policy
        step(1'b1, 3, 8'h11, 1'b0, 0);
        step(1'b1, 3, 8'h22, 1'b1, 3);
        chk("coll_m0_dout", 32'(dout_w[0]), 32'h11);
        chk("coll_m1_dout", 32'(dout_w[1]), 32'h22);
        chk("coll_m1_dv", 32'(dv_w[1]), 32'd1);
        chk("coll_m2_dv", 32'(dv_w[2]), 32'd0);
        chk("coll_m2_hold", 32'(dout_w[2]), 32'd100);
        chk("coll_count1", 32'(cc_w[0]), 32'd1);
        step(1'b0, 0, 0, 1'b1, 3);
        chk("after_coll_m0", 32'(dout_w[0]), 32'h22);
        chk("after_coll_m2", 32'(dout_w[2]), 32'h22);

        // Output-register latency: valid exactly two edges after re
        step(1'b1, 5, 8'h5A, 1'b0, 0);
        step(1'b0, 0, 0, 1'b1, 5);
        chk("oreg_lat1_dv", 32'(dv_w[3]), 32'd0);
        step(1'b0, 0, 0, 1'b0, 0);
        chk("oreg_lat2_dv", 32'(dv_w[3]), 32'd1);
        chk("oreg_lat2_dout", 32'(dout_w[3]), 32'h5A);
        step(1'b0, 0, 0, 1'b0, 0);
        chk("oreg_lat3_dv", 32'(dv_w[3]), 32'd0);
        chk("oreg_hold_dout", 32'(dout_w[3]), 32'h5A);

        // Random traffic on a narrow address range to provoke collisions
        repeat (200) rand_step(3);

        // Saturation of the collision counter
        repeat (300) step(1'b1, 6, int'($urandom_range(0, 255)), 1'b1, 6);
        chk("coll_sat", 32'(cc_w[0]), 32'd255);
        step(1'b1, 6, 8'h01, 1'b1, 6);
        chk("coll_sat_stay", 32'(cc_w[0]), 32'd255);

        // Reset while READY kills an in-flight OUT_REG read
        step(1'b0, 0, 0, 1'b1, 6);
        do_reset();
        chk("abort_dv_oreg", 32'(dv_w[3]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
